reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_reset_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer: debounces a pushbutton and a software request into a fixed-length,
// registered active-low reset pulse followed by a quiet window. Optional macro RESET_SEQUENCER_CAUSE_EN.
module reset_sequencer #(
  parameter int HOLD_CYCLES     = 16,
  parameter int QUIET_CYCLES    = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SW_RST_REQ,
  input  logic       EXT_RST_N,
  output logic       OUT_RST_N,
  output logic       RST_BUSY,
  output logic [1:0] RST_CAUSE
);

  localparam logic [1:0] ST_ASSERT = 2'd0;
  localparam logic [1:0] ST_QUIET  = 2'd1;
  localparam logic [1:0] ST_IDLE   = 2'd2;

  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYCLES - 1);
  localparam logic [7:0] DEB_MAX    = 8'(DEBOUNCE_CYCLES);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [7:0] deb_q, deb_d;
  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       out_rst_n_q, out_rst_n_d;
  logic       busy_q, busy_d;
  logic       ext_req_s;
  logic       req_s;
  logic       pending_s;
  logic       enter_assert_s;

  assign ext_req_s = (deb_q == DEB_MAX);
  assign req_s     = SW_RST_REQ | ext_req_s;

  // Synchronizer and saturating debounce counter for the pushbutton
  always_comb begin
    sync1_d = EXT_RST_N;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    if (sync2_q == 1'b0) begin
      if (deb_q != DEB_MAX) begin
        deb_d = deb_q + 8'd1;
      end else begin
        deb_d = deb_q;
      end
    end else begin
      deb_d = 8'd0;
    end
  end

  // Sequencer FSM; a held-down button pins the hold counter at zero
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    enter_assert_s = 1'b0;
    case (state_q)
      ST_ASSERT: begin
        if (ext_req_s) begin
          cnt_d = 8'd0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_QUIET;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_QUIET: begin
        if (cnt_q == QUIET_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_IDLE: begin
        if (req_s | pending_s) begin
          state_d        = ST_ASSERT;
          cnt_d          = 8'd0;
          enter_assert_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_ASSERT;
        cnt_d   = 8'd0;
      end
    endcase
    out_rst_n_d = (state_d != ST_ASSERT);
    busy_d      = (state_d != ST_IDLE);
  end

  // Core state registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      deb_q       <= 8'd0;
      state_q     <= ST_ASSERT;
      cnt_q       <= 8'd0;
      out_rst_n_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_rst_n_q <= out_rst_n_d;
      busy_q      <= busy_d;
    end
  end

  assign OUT_RST_N = out_rst_n_q;
  assign RST_BUSY  = busy_q;

`ifdef RESET_SEQUENCER_CAUSE_EN
  logic       pend_sw_q, pend_sw_d;
  logic       pend_ext_q, pend_ext_d;
  logic [1:0] cause_q, cause_d;

  assign pending_s = pend_sw_q | pend_ext_q;

  // Per-source pending bits and sticky cause; ASSERT-time requests merge into the cause
  always_comb begin
    pend_sw_d  = pend_sw_q;
    pend_ext_d = pend_ext_q;
    cause_d    = cause_q;
    if (enter_assert_s) begin
      pend_sw_d  = 1'b0;
      pend_ext_d = 1'b0;
      cause_d    = {ext_req_s | pend_ext_q, SW_RST_REQ | pend_sw_q};
    end else if (state_q == ST_QUIET) begin
      pend_sw_d  = pend_sw_q | SW_RST_REQ;
      pend_ext_d = pend_ext_q | ext_req_s;
    end else if (state_q == ST_ASSERT) begin
      cause_d = cause_q | {ext_req_s, SW_RST_REQ};
    end else begin
      cause_d = cause_q;
    end
  end

  // Cause and pending registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_sw_q  <= 1'b0;
      pend_ext_q <= 1'b0;
      cause_q    <= 2'b00;
    end else begin
      pend_sw_q  <= pend_sw_d;
      pend_ext_q <= pend_ext_d;
      cause_q    <= cause_d;
    end
  end

  assign RST_CAUSE = cause_q;
`else
  logic pend_q, pend_d;

  assign pending_s = pend_q;

  // Single pending flag for requests that land in the quiet window
  always_comb begin
    pend_d = pend_q;
    if (enter_assert_s) begin
      pend_d = 1'b0;
    end else if ((state_q == ST_QUIET) && req_s) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  // Pending register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign RST_CAUSE = 2'b00;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench for reset_sequencer with default parameters (16/8/4).
module tb_reset_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       SW_RST_REQ;
  logic       EXT_RST_N;
  logic       OUT_RST_N;
  logic       RST_BUSY;
  logic [1:0] RST_CAUSE;

  int total  = 0;
  int passed = 0;
  int n;
  int first;
  logic seen;

`ifdef RESET_SEQUENCER_CAUSE_EN
  localparam logic [1:0] C_SW   = 2'b01;
  localparam logic [1:0] C_EXT  = 2'b10;
  localparam logic [1:0] C_BOTH = 2'b11;
`else
  localparam logic [1:0] C_SW   = 2'b00;
  localparam logic [1:0] C_EXT  = 2'b00;
  localparam logic [1:0] C_BOTH = 2'b00;
`endif

  reset_sequencer dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .SW_RST_REQ (SW_RST_REQ),
    .EXT_RST_N  (EXT_RST_N),
    .OUT_RST_N  (OUT_RST_N),
    .RST_BUSY   (RST_BUSY),
    .RST_CAUSE  (RST_CAUSE)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Ticks until OUT_RST_N equals target; the returned count exposes an expired bound.
  task automatic wait_out(input logic target, output int cnt);
    cnt = 0;
    while (OUT_RST_N !== target && cnt < 200) begin
      tick();
      cnt = cnt + 1;
    end
  endtask

  task automatic wait_busy_low(output int cnt);
    cnt = 0;
    while (RST_BUSY !== 1'b0 && cnt < 200) begin
      tick();
      cnt = cnt + 1;
    end
  endtask

  initial begin
    RST_N      = 1'b0;
    SW_RST_REQ = 1'b0;
    EXT_RST_N  = 1'b1;
    repeat (3) tick();
    check("reset_out", 32'(OUT_RST_N), 32'd0);
    check("reset_busy", 32'(RST_BUSY), 32'd1);
    check("reset_cause", 32'(RST_CAUSE), 32'd0);

    // Power-on sequence
    RST_N = 1'b1;
    wait_out(1'b1, n);
    check("por_hold_len", n, 32'd16);
    wait_busy_low(n);
    check("por_quiet_len", n, 32'd8);
    check("por_cause", 32'(RST_CAUSE), 32'd0);

    // One-cycle software request
    SW_RST_REQ = 1'b1;
    tick();
    SW_RST_REQ = 1'b0;
    check("sw_latency_out", 32'(OUT_RST_N), 32'd0);
    check("sw_latency_busy", 32'(RST_BUSY), 32'd1);
    wait_out(1'b1, n);
    check("sw_hold_len", n, 32'd16);
    check("sw_cause", 32'(RST_CAUSE), 32'(C_SW));
    wait_busy_low(n);
    check("sw_quiet_len", n, 32'd8);

    // Short button glitch is filtered
    EXT_RST_N = 1'b0;
    repeat (3) tick();
    EXT_RST_N = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (OUT_RST_N !== 1'b1) seen = 1'b1;
    end
    check("ext_short_ignored", 32'(seen), 32'd0);

    // Long press: 2 sync + 4 debounce cycles, then held until 16 after release settles
    EXT_RST_N = 1'b0;
    first = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (first == 0 && OUT_RST_N === 1'b0) first = i;
    end
    check("ext_assert_edge", first, 32'd7);
    EXT_RST_N = 1'b1;
    wait_out(1'b1, n);
    check("ext_release_len", n, 32'd19);
    check("ext_cause", 32'(RST_CAUSE), 32'(C_EXT));
    wait_busy_low(n);
    check("ext_quiet_len", n, 32'd8);

    // Request in the third quiet cycle becomes pending
    SW_RST_REQ = 1'b1;
    tick();
    SW_RST_REQ = 1'b0;
    wait_out(1'b1, n);
    check("pend_first_len", n, 32'd16);
    repeat (2) tick();
    SW_RST_REQ = 1'b1;
    tick();
    SW_RST_REQ = 1'b0;
    check("pend_no_restart", 32'(OUT_RST_N), 32'd1);
    wait_out(1'b0, n);
    check("pend_second_start", n, 32'd6);
    wait_out(1'b1, n);
    check("pend_second_len", n, 32'd16);
    check("pend_cause", 32'(RST_CAUSE), 32'(C_SW));
    wait_busy_low(n);
    check("pend_quiet_len", n, 32'd8);

    // Request during ASSERT is merged
    SW_RST_REQ = 1'b1;
    tick();
    SW_RST_REQ = 1'b0;
    repeat (5) tick();
    SW_RST_REQ = 1'b1;
    tick();
    SW_RST_REQ = 1'b0;
    wait_out(1'b1, n);
    check("merge_remaining", n, 32'd10);
    wait_busy_low(n);
    check("merge_quiet_len", n, 32'd8);
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (OUT_RST_N !== 1'b1) seen = 1'b1;
    end
    check("merge_no_second", 32'(seen), 32'd0);

    // Software and debounced button in the same idle cycle
    EXT_RST_N = 1'b0;
    repeat (4) tick();
    EXT_RST_N = 1'b1;
    repeat (2) tick();
    check("both_pre_out", 32'(OUT_RST_N), 32'd1);
    SW_RST_REQ = 1'b1;
    tick();
    SW_RST_REQ = 1'b0;
    check("both_latency", 32'(OUT_RST_N), 32'd0);
    wait_out(1'b1, n);
    check("both_hold_len", n, 32'd16);
    check("both_cause", 32'(RST_CAUSE), 32'(C_BOTH));
    wait_busy_low(n);
    check("both_quiet_len", n, 32'd8);
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (OUT_RST_N !== 1'b1) seen = 1'b1;
    end
    check("both_single_event", 32'(seen), 32'd0);

    // RST_N pulse at ASSERT count 10 restarts a full hold
    SW_RST_REQ = 1'b1;
    tick();
    SW_RST_REQ = 1'b0;
    repeat (10) tick();
    RST_N = 1'b0;
    #1;
    check("abort_out", 32'(OUT_RST_N), 32'd0);
    check("abort_cause", 32'(RST_CAUSE), 32'd0);
    tick();
    RST_N = 1'b1;
    wait_out(1'b1, n);
    check("abort_hold_len", n, 32'd16);
    wait_busy_low(n);
    check("abort_quiet_len", n, 32'd8);

    // RST_N during QUIET drops the output asynchronously
    SW_RST_REQ = 1'b1;
    tick();
    SW_RST_REQ = 1'b0;
    wait_out(1'b1, n);
    check("quiet_abort_pre", n, 32'd16);
    repeat (2) tick();
    RST_N = 1'b0;
    #1;
    check("quiet_abort_out", 32'(OUT_RST_N), 32'd0);
    check("quiet_abort_busy", 32'(RST_BUSY), 32'd1);
    tick();
    RST_N = 1'b1;
    wait_out(1'b1, n);
    check("quiet_abort_len", n, 32'd16);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
